// File: rtl/riscv_dcache_pkg.sv
// Shared types and geometry helpers for the riscv_dcache data cache.
//   dcache_state_t : controller states (IDLE, WB, FILL, WT, DONE)
//   index_w/offset_w/tag_w : field widths of the word address
//                            {tag, index, offset}
package riscv_dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_WT,
        S_DONE
    } dcache_state_t;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int words);
        return addr_w - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Storage arrays of the direct-mapped data cache.
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset (clears valid/dirty only)
//   index                    : line selected for both read and write
//   line_data/line_tag       : combinational read of the whole selected line and its tag
//   line_valid/line_dirty    : combinational status of the selected line
//   word_we/word_offset/word_data : single-word write into the selected line
//   fill_done/fill_tag       : line refill complete -> write tag, set valid, clear dirty
//   dirty_set/dirty_clr      : dirty bit maintenance for the selected line
module dcache_store
    import riscv_dcache_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int LINES  = 16,
    parameter  int WORDS  = 4,
    parameter  int TAG_W  = 4,
    localparam int IDX_W  = index_w(LINES),
    localparam int OFF_W  = offset_w(WORDS)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [IDX_W-1:0]              index,
    output logic [WORDS-1:0][DATA_W-1:0]  line_data,
    output logic [TAG_W-1:0]              line_tag,
    output logic                          line_valid,
    output logic                          line_dirty,
    input  logic                          word_we,
    input  logic [OFF_W-1:0]              word_offset,
    input  logic [DATA_W-1:0]             word_data,
    input  logic                          fill_done,
    input  logic [TAG_W-1:0]              fill_tag,
    input  logic                          dirty_set,
    input  logic                          dirty_clr
);

    logic [WORDS-1:0][DATA_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]             tag_q  [LINES];
    logic [LINES-1:0]             valid_q;
    logic [LINES-1:0]             dirty_q;

    assign line_data  = data_q[index];
    assign line_tag   = tag_q[index];
    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];

    // NOTE: data and tag arrays carry no reset; a line is only trusted once
    // its valid bit is set, so clearing valid is enough and keeps these as RAM.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            // NOTE: all state updates are non-blocking so every reader sees the
            // pre-edge value regardless of block ordering.
            if (word_we)   data_q[index][word_offset] <= word_data;
            if (fill_done) tag_q[index]               <= fill_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (dirty_set) dirty_q[index] <= 1'b1;
            if (dirty_clr) dirty_q[index] <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// Parametrised direct-mapped data cache between the single-cycle core and a
// word-wide req/ack memory port. Selectable write-back/allocate or
// write-through/no-allocate policy.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   MemRead_i, MemWrite_i          : core load/store request (store wins if both)
//   WordAddress_i, DataIn_i        : request word address and store data
//   Stall_o                        : combinational, freezes the core until served
//   DataOut_o                      : hit word on a read hit, else 0
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : registered memory beat request
//   mem_rdata_i, mem_ack_i         : memory beat response
module riscv_dcache
    import riscv_dcache_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LINES      = 16,
    parameter int WORDS      = 4,
    parameter int WRITE_BACK = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] WordAddress_i,
    input  logic [DATA_W-1:0] DataIn_i,
    output logic              Stall_o,
    output logic [DATA_W-1:0] DataOut_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W   = index_w(LINES);
    localparam int OFF_W   = offset_w(WORDS);
    localparam int TAG_W   = tag_w(ADDR_W, LINES, WORDS);
    localparam bit WB_MODE = (WRITE_BACK != 0);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

    dcache_state_t state;
    logic [OFF_W-1:0] cnt;
    logic [OFF_W-1:0] next_cnt;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic [OFF_W-1:0] req_offset;

    logic [WORDS-1:0][DATA_W-1:0] line_data;
    logic [TAG_W-1:0]             line_tag;
    logic                         line_valid;
    logic                         line_dirty;

    logic              is_read;
    logic              hit;
    logic              beat_done;
    logic              last_beat;
    logic              wb_write_hit;
    logic              served;
    logic              miss_fill;
    logic              store_we;
    logic [OFF_W-1:0]  store_offset;
    logic [DATA_W-1:0] store_data;
    logic              fill_done;
    logic              dirty_set;
    logic              dirty_clr;

    assign {req_tag, req_index, req_offset} = WordAddress_i;

    assign is_read      = MemRead_i && !MemWrite_i;
    assign hit          = line_valid && (line_tag == req_tag);
    assign beat_done    = mem_req_o && mem_ack_i;
    assign last_beat    = (cnt == LAST_OFF);
    assign next_cnt     = cnt + 1'b1;
    assign wb_write_hit = WB_MODE && MemWrite_i && hit;
    assign served       = (is_read && hit) || wb_write_hit;
    // A miss needs a line fill for loads always, and for stores only when allocating.
    assign miss_fill    = !hit && (is_read || (WB_MODE && MemWrite_i));

    assign Stall_o   = ((state == S_IDLE) && (MemRead_i || MemWrite_i) && !served)
                     || (state inside {S_WB, S_FILL, S_WT});
    assign DataOut_o = (MemRead_i && hit) ? line_data[req_offset] : '0;

    // Array writes: store hit in IDLE, refill beats, and the write-through
    // update of an already cached word (no allocate on a miss).
    assign store_we     = ((state == S_IDLE) && wb_write_hit)
                        || ((state == S_FILL) && beat_done)
                        || ((state == S_WT) && beat_done && hit);
    assign store_offset = (state == S_FILL) ? cnt : req_offset;
    assign store_data   = (state == S_FILL) ? mem_rdata_i : DataIn_i;
    assign fill_done    = (state == S_FILL) && beat_done && last_beat;
    assign dirty_set    = (state == S_IDLE) && wb_write_hit;
    assign dirty_clr    = (state == S_WB) && beat_done && last_beat;

    dcache_store #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .index       (req_index),
        .line_data   (line_data),
        .line_tag    (line_tag),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .word_we     (store_we),
        .word_offset (store_offset),
        .word_data   (store_data),
        .fill_done   (fill_done),
        .fill_tag    (req_tag),
        .dirty_set   (dirty_set),
        .dirty_clr   (dirty_clr)
    );

    // Controller with registered memory-port outputs: each beat's request is
    // loaded one edge ahead, so address/data are stable until the ack.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!WB_MODE && MemWrite_i) begin
                        state       <= S_WT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= WordAddress_i;
                        mem_wdata_o <= DataIn_i;
                    end else if (miss_fill) begin
                        cnt       <= '0;
                        mem_req_o <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state       <= S_WB;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {line_tag, req_index, {OFF_W{1'b0}}};
                            mem_wdata_o <= line_data[0];
                        end else begin
                            state       <= S_FILL;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {req_tag, req_index, {OFF_W{1'b0}}};
                            mem_wdata_o <= '0;
                        end
                    end
                end
                S_WB: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            state       <= S_FILL;
                            cnt         <= '0;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {req_tag, req_index, {OFF_W{1'b0}}};
                            mem_wdata_o <= '0;
                        end else begin
                            cnt         <= next_cnt;
                            mem_addr_o  <= mem_addr_o + 1'b1;
                            mem_wdata_o <= line_data[next_cnt];
                        end
                    end
                end
                S_FILL: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            state      <= S_IDLE;
                            cnt        <= '0;
                            mem_req_o  <= 1'b0;
                            mem_addr_o <= '0;
                        end else begin
                            cnt        <= next_cnt;
                            mem_addr_o <= mem_addr_o + 1'b1;
                        end
                    end
                end
                S_WT: begin
                    if (beat_done) begin
                        state       <= S_DONE;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                    end
                end
                // One unstalled cycle so the core moves past the store before
                // the cache looks at the request inputs again.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dcache.sv
// Self-checking bench for riscv_dcache: one write-back instance (index 0) and
// one write-through instance (index 1), each with its own memory model.
module tb_riscv_dcache;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int MEMSZ = 1 << AW;

    typedef struct {
        bit             we;
        int             addr;
        logic [DW-1:0]  data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rd     [2];
    logic          wr     [2];
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] din    [2];
    logic          stall  [2];
    logic [DW-1:0] dout   [2];
    logic          mreq   [2];
    logic          mwe    [2];
    logic          mack   [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic [DW-1:0] mrdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        riscv_dcache #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .LINES      (LINES),
            .WORDS      (WORDS),
            .WRITE_BACK ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk_i         (clk),
            .reset_i       (rst),
            .MemRead_i     (rd[g]),
            .MemWrite_i    (wr[g]),
            .WordAddress_i (addr[g]),
            .DataIn_i      (din[g]),
            .Stall_o       (stall[g]),
            .DataOut_o     (dout[g]),
            .mem_req_o     (mreq[g]),
            .mem_we_o      (mwe[g]),
            .mem_addr_o    (maddr[g]),
            .mem_wdata_o   (mwdata[g]),
            .mem_rdata_i   (mrdata[g]),
            .mem_ack_i     (mack[g])
        );
    end

    // ---------------- memory model ----------------
    int            ack_delay [2];
    int            wait_cnt  [2];
    logic          mem_init;
    logic [DW-1:0] mem [2][MEMSZ];

    function automatic logic [DW-1:0] init_val(input int d, input int a);
        return DW'(32'hC0DE_0000 ^ (d << 12) ^ (a * 32'h9E37));
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mack[d]   = mreq[d] && (wait_cnt[d] >= ack_delay[d]);
            mrdata[d] = mem[d][maddr[d]];
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                for (int i = 0; i < MEMSZ; i++) mem[d][i] <= init_val(d, i);
                wait_cnt[d] <= 0;
            end else begin
                if (mreq[d] && mack[d] && mwe[d]) mem[d][maddr[d]] <= mwdata[d];
                wait_cnt[d] <= (mreq[d] && !mack[d]) ? wait_cnt[d] + 1 : 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [2][MEMSZ];
    bit            c_valid [2][LINES];
    bit            c_dirty [2][LINES];
    int            c_tag   [2][LINES];
    logic [DW-1:0] c_data  [2][LINES][WORDS];
    beat_t         beat_q  [2][$];
    logic [DW-1:0] rd_q    [2][$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_status();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < LINES; i++) begin
                c_valid[d][i] = 1'b0;
                c_dirty[d][i] = 1'b0;
            end
    endtask

    // Instance 0 is write-back/allocate, instance 1 write-through/no-allocate.
    task automatic model_access(input int d, input bit is_rd, input bit is_wr, input int a,
                                input logic [DW-1:0] data, output int exp_stall);
        int  off, idx, tg, base, vbase, beats, per;
        bit  hit;
        off  = a % WORDS;
        idx  = (a / WORDS) % LINES;
        tg   = a / (WORDS * LINES);
        base = a - off;
        hit  = c_valid[d][idx] && (c_tag[d][idx] == tg);
        per  = ack_delay[d] + 1;
        exp_stall = 0;
        if (is_wr && d == 1) begin
            beat_q[d].push_back('{we: 1'b1, addr: a, data: data});
            ref_mem[d][a] = data;
            if (hit) c_data[d][idx][off] = data;
            exp_stall = 1 + per;
            return;
        end
        if (!hit) begin
            beats = 0;
            if (c_valid[d][idx] && c_dirty[d][idx]) begin
                vbase = (c_tag[d][idx] * LINES + idx) * WORDS;
                for (int k = 0; k < WORDS; k++) begin
                    beat_q[d].push_back('{we: 1'b1, addr: vbase + k, data: c_data[d][idx][k]});
                    ref_mem[d][vbase + k] = c_data[d][idx][k];
                end
                beats += WORDS;
            end
            for (int k = 0; k < WORDS; k++) begin
                beat_q[d].push_back('{we: 1'b0, addr: base + k, data: '0});
                c_data[d][idx][k] = ref_mem[d][base + k];
            end
            beats += WORDS;
            c_tag[d][idx]   = tg;
            c_valid[d][idx] = 1'b1;
            c_dirty[d][idx] = 1'b0;
            exp_stall = 1 + beats * per;
        end
        if (is_wr) begin
            c_data[d][idx][off] = data;
            c_dirty[d][idx]     = 1'b1;
        end else if (is_rd) begin
            rd_q[d].push_back(c_data[d][idx][off]);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          prev_wait  [2];
    logic [AW-1:0] prev_addr  [2];
    logic [DW-1:0] prev_wdata [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mreq[d] && mack[d]) begin
                if (beat_q[d].size() == 0) begin
                    check($sformatf("beat_expected[%0d] addr=0x%0h", d, maddr[d]), 0, 1);
                end else begin
                    beat_t b;
                    b = beat_q[d].pop_front();
                    check($sformatf("beat_we[%0d]", d), mwe[d], b.we);
                    check($sformatf("beat_addr[%0d]", d), maddr[d], b.addr);
                    if (b.we) check($sformatf("beat_wdata[%0d]", d), mwdata[d], b.data);
                end
            end
            if (!rst && mreq[d] && prev_wait[d]) begin
                check($sformatf("addr_stable[%0d]", d), maddr[d], prev_addr[d]);
                if (mwe[d]) check($sformatf("wdata_stable[%0d]", d), mwdata[d], prev_wdata[d]);
            end
            prev_wait[d]  = !rst && mreq[d] && !mack[d];
            prev_addr[d]  = maddr[d];
            prev_wdata[d] = mwdata[d];
            if (!rst && rd[d] && !wr[d] && !stall[d]) begin
                if (rd_q[d].size() == 0) begin
                    check($sformatf("read_expected[%0d]", d), 0, 1);
                end else begin
                    check($sformatf("read_data[%0d] addr=0x%0h", d, addr[d]), dout[d], rd_q[d].pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic access(input int d, input bit is_rd, input bit is_wr, input int a,
                          input logic [DW-1:0] data);
        int exp_stall, n;
        model_access(d, is_rd, is_wr, a, data, exp_stall);
        rd[d] = is_rd; wr[d] = is_wr; addr[d] = AW'(a); din[d] = data;
        n = 0;
        @(negedge clk);
        while (stall[d] && n < 300) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("stall_cycles[%0d] addr=0x%0h rd=%0b wr=%0b", d, a, is_rd, is_wr), n, exp_stall);
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, a, op;
        rst = 1'b1; mem_init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0; ack_delay[k] = 0;
            for (int i = 0; i < MEMSZ; i++) ref_mem[k][i] = init_val(k, i);
        end
        model_clear_status();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_stall[%0d]", k), stall[k], 0);
            check($sformatf("rst_dout[%0d]", k), dout[k], 0);
            check($sformatf("rst_mem_req[%0d]", k), mreq[k], 0);
            check($sformatf("rst_mem_we[%0d]", k), mwe[k], 0);
            check($sformatf("rst_mem_addr[%0d]", k), maddr[k], 0);
            check($sformatf("rst_mem_wdata[%0d]", k), mwdata[k], 0);
        end
        @(posedge clk); #1;

        // Clean read miss, then a hit on the same line
        access(0, 1, 0, 'h010, '0);
        access(0, 1, 0, 'h011, '0);
        // Write-back store hit, then a conflicting read forces a dirty eviction
        access(0, 0, 1, 'h011, 32'hDEADBEEF);
        access(0, 1, 0, 'h051, '0);
        access(0, 1, 0, 'h010, '0);
        // Write-through store miss (no allocate), then read it back through a fill
        access(1, 0, 1, 'h020, 32'd5);
        access(1, 1, 0, 'h020, '0);
        access(1, 0, 1, 'h021, 32'h0BADF00D);
        access(1, 1, 0, 'h021, '0);
        // Slow memory: three wait cycles per beat
        ack_delay[0] = 3;
        access(0, 1, 0, 'h0A4, '0);
        ack_delay[0] = 0;

        // Reset during the second refill beat
        for (int k = 0; k < 2; k++) beat_q[0].push_back('{we: 1'b0, addr: 'h0C8 + k, data: '0});
        rd[0] = 1'b1; addr[0] = AW'('h0C8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rd[0] = 1'b0;
        model_clear_status();
        @(negedge clk);
        check("abort_mem_req", mreq[0], 0);
        check("abort_stall", stall[0], 0);
        @(posedge clk); #1;
        access(0, 1, 0, 'h0C8, '0);

        // Both request lines high on a write-back hit: handled as a store
        access(0, 1, 1, 'h0C9, 32'h12345678);
        access(0, 1, 0, 'h0C9, '0);
        access(0, 1, 0, 'h2C8, '0);
        access(0, 1, 0, 'h0C9, '0);

        // Randomized traffic on both instances
        for (int it = 0; it < 300; it++) begin
            d  = $urandom_range(0, 1);
            a  = $urandom_range(0, 255);
            op = $urandom_range(0, 2);
            ack_delay[d] = $urandom_range(0, 2);
            access(d, op != 1, op != 0, a, $urandom);
        end

        repeat (3) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("beats_left[%0d]", k), beat_q[k].size(), 0);
            check($sformatf("reads_left[%0d]", k), rd_q[k].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
